// File: rtl/scan_pkg.sv
// Shared definitions for the peak bin scanner.
//   NUM_BINS_DEF / MAG_W_DEF : default spectrum size and magnitude width
//   LANE_W                   : width of the lane number inside one 4-bin word
//   scan_state_e             : sequencer states
package scan_pkg;

    localparam int unsigned NUM_BINS_DEF = 64;
    localparam int unsigned MAG_W_DEF    = 20;
    localparam int unsigned LANE_W       = 2;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StFinish
    } scan_state_e;

endpackage

// File: rtl/max4_select.sv
// Registered four-way maximum select over one memory word of four bins.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : drops the word presented this cycle (scan abort)
//   in_valid   : in_mags holds a valid word
//   in_mags    : four magnitudes, lane k at [k*MAG_W +: MAG_W]
//   lane, mag  : registered winning lane and its magnitude
//   valid      : registered valid for lane/mag
module max4_select
    import scan_pkg::*;
#(
    parameter int unsigned MAG_W = MAG_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    input  logic [4*MAG_W-1:0] in_mags,
    output logic [LANE_W-1:0]  lane,
    output logic [MAG_W-1:0]   mag,
    output logic               valid
);

    logic [LANE_W-1:0] best_lane;
    logic [MAG_W-1:0]  best_mag;

    // Strictly-greater replacement scanning upward keeps the lowest lane on ties.
    always_comb begin
        best_lane = '0;
        best_mag  = in_mags[0 +: MAG_W];
        for (int k = 1; k < 4; k++) begin
            if (in_mags[k*MAG_W +: MAG_W] > best_mag) begin
                best_mag  = in_mags[k*MAG_W +: MAG_W];
                best_lane = LANE_W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            lane  <= '0;
            mag   <= '0;
        end else begin
            valid <= in_valid && !clr;
            if (in_valid && !clr) begin
                lane <= best_lane;
                mag  <= best_mag;
            end
        end
    end

endmodule

// File: rtl/peak_bin_scanner.sv
// Scans a magnitude memory (four bins per word) and reports the peak bin.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : begin a scan (accepted only when idle); min_mag captured then
//   abort      : terminate a scan in progress, no done pulse
//   min_mag    : threshold for peak_valid
//   rd_en      : memory read strobe
//   rd_addr    : memory word address, word g holds bins 4g..4g+3
//   rd_data    : word returned one cycle after rd_en
//   busy       : scan in progress
//   done       : one-cycle pulse when peak_* update
//   peak_idx   : winning bin index
//   peak_mag   : winning magnitude
//   peak_valid : peak_mag >= captured min_mag
module peak_bin_scanner
    import scan_pkg::*;
#(
    parameter int unsigned NUM_BINS = NUM_BINS_DEF,
    parameter int unsigned MAG_W    = MAG_W_DEF,
    parameter int unsigned IDX_W    = $clog2(NUM_BINS),
    parameter int unsigned ADDR_W   = (NUM_BINS / 4 > 1) ? $clog2(NUM_BINS / 4) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [MAG_W-1:0]   min_mag,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [4*MAG_W-1:0] rd_data,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   peak_idx,
    output logic [MAG_W-1:0]   peak_mag,
    output logic               peak_valid
);

    localparam int unsigned       NumGroups = NUM_BINS / 4;
    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(NumGroups - 1);
    localparam int unsigned       RunW      = ADDR_W + LANE_W;

    scan_state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [MAG_W-1:0]  thr_q;

    logic start_acc;
    logic abort_acc;

    // Read-return pipeline tags: data valid, and "this is the last group".
    logic rd_vld_q;
    logic rd_last_q;
    logic s1_last_q;

    logic [LANE_W-1:0] s1_lane;
    logic [MAG_W-1:0]  s1_mag;
    logic              s1_valid;

    // Running-max stage.
    logic [ADDR_W-1:0] grp_q;
    logic              first_q;
    logic [MAG_W-1:0]  run_mag_q;
    logic [RunW-1:0]   run_idx_q;

    logic              done_q;
    logic [IDX_W-1:0]  peak_idx_q;
    logic [MAG_W-1:0]  peak_mag_q;
    logic              peak_valid_q;

    assign start_acc = (state_q == StIdle) && start;
    assign abort_acc = (state_q != StIdle) && abort;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (addr_q == LastAddr) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // The last group sits in stage 1 now and enters the running max at this edge.
                if (abort) begin
                    state_d = StIdle;
                end else if (s1_last_q) begin
                    state_d = StFinish;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------ address and threshold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            thr_q  <= '0;
        end else if (start_acc) begin
            addr_q <= '0;
            thr_q  <= min_mag;
        end else if (state_q == StRead && addr_q != LastAddr && !abort) begin
            addr_q <= addr_q + ADDR_W'(1);
        end
    end

    assign rd_en   = (state_q == StRead);
    assign rd_addr = addr_q;

    // ------------------------------------------------------- read pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            s1_last_q <= 1'b0;
        end else begin
            rd_vld_q  <= rd_en && !abort_acc;
            rd_last_q <= rd_en && (addr_q == LastAddr) && !abort_acc;
            s1_last_q <= rd_last_q && !abort_acc;
        end
    end

    max4_select #(
        .MAG_W (MAG_W)
    ) u_max4_select (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (abort_acc),
        .in_valid (rd_vld_q),
        .in_mags  (rd_data),
        .lane     (s1_lane),
        .mag      (s1_mag),
        .valid    (s1_valid)
    );

    // ------------------------------------------------------- running max
    // Groups arrive in address order, so a consumed-group counter supplies g.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grp_q     <= '0;
            first_q   <= 1'b0;
            run_mag_q <= '0;
            run_idx_q <= '0;
        end else if (start_acc) begin
            grp_q   <= '0;
            first_q <= 1'b1;
        end else if (s1_valid) begin
            // Strictly greater: cross-group ties keep the earlier bin.
            if (first_q || s1_mag > run_mag_q) begin
                run_mag_q <= s1_mag;
                run_idx_q <= {grp_q, s1_lane};
            end
            grp_q   <= grp_q + ADDR_W'(1);
            first_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------ results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q       <= 1'b0;
            peak_idx_q   <= '0;
            peak_mag_q   <= '0;
            peak_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == StFinish && !abort_acc) begin
                done_q       <= 1'b1;
                peak_idx_q   <= run_idx_q[IDX_W-1:0];
                peak_mag_q   <= run_mag_q;
                peak_valid_q <= (run_mag_q >= thr_q);
            end
        end
    end

    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign peak_idx   = peak_idx_q;
    assign peak_mag   = peak_mag_q;
    assign peak_valid = peak_valid_q;

endmodule

// File: tb/tb_peak_bin_scanner.sv
// Directed bench for peak_bin_scanner (NUM_BINS=64, MAG_W=20).
module tb_peak_bin_scanner;

    localparam int NB = 64;
    localparam int MW = 20;
    localparam int IW = 6;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [MW-1:0] min_mag;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [4*MW-1:0] rd_data = '0;
    logic          busy;
    logic          done;
    logic [IW-1:0] peak_idx;
    logic [MW-1:0] peak_mag;
    logic          peak_valid;

    logic [MW-1:0] mem [NB];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int addr_log[$];
    int first_rd = 0;
    int last_rd  = 0;

    always #5 clk = ~clk;

    peak_bin_scanner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .min_mag    (min_mag),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .peak_idx   (peak_idx),
        .peak_mag   (peak_mag),
        .peak_valid (peak_valid)
    );

    // Memory model: one-cycle read latency; also logs the address stream.
    always @(posedge clk) begin
        cyc++;
        if (rd_en) begin
            if (addr_log.size() == 0) first_rd = cyc;
            last_rd = cyc;
            addr_log.push_back(int'(rd_addr));
            for (int k = 0; k < 4; k++) rd_data[k*MW +: MW] <= mem[4*int'(rd_addr) + k];
        end
    end

    task automatic fill(input logic [MW-1:0] bg);
        for (int i = 0; i < NB; i++) mem[i] = bg;
    endtask

    // Runs one scan. xs/ab/mc/rc are cycle numbers (after the start edge) at which an
    // extra start, abort, min_mag change or reset is driven; -1 disables.
    // lat = cycles from start edge to done, 0 if no done within the bound.
    task automatic scan(input logic [MW-1:0] mm, input int xs, input int ab, input int mc,
                        input logic [MW-1:0] mm2, input int rc,
                        output int lat, output logic busy_ab, output int start_cyc);
        @(negedge clk);
        addr_log.delete();
        min_mag = mm;
        start   = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        start_cyc = cyc;
        lat       = 0;
        busy_ab   = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (k == ab + 1) busy_ab = busy;
            start = (k == xs);
            abort = (k == ab);
            rst_n = (k != rc);
            if (k == mc) min_mag = mm2;
        end
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        start   = 1'b1;
        abort   = 1'b0;
        min_mag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
        total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%0b want=0", rd_en); end
        total++; if (peak_idx !== 6'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", peak_idx); end
        total++; if (peak_mag !== 20'd0) begin bad++; $display("FAIL reset_mag got=%0d want=0", peak_mag); end
        total++; if (peak_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", peak_valid); end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_peak;
        int lat, sc;
        logic ba;
        fill(20'd10);
        mem[37] = 20'd1000;
        scan(20'd500, -1, -1, -1, '0, -1, lat, ba, sc);
        total++; if (lat != 19) begin bad++; $display("FAIL single_latency got=%0d want=19", lat); end
        total++; if (peak_idx !== 6'd37) begin bad++; $display("FAIL single_idx got=%0d want=37", peak_idx); end
        total++; if (peak_mag !== 20'd1000) begin bad++; $display("FAIL single_mag got=%0d want=1000", peak_mag); end
        total++; if (peak_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", peak_valid); end
        total++; if (addr_log.size() != 16) begin bad++; $display("FAIL single_addr_count got=%0d want=16", addr_log.size()); end
        for (int i = 0; i < 16 && i < addr_log.size(); i++) begin
            total++;
            if (addr_log[i] != i) begin bad++; $display("FAIL single_addr[%0d] got=%0d want=%0d", i, addr_log[i], i); end
        end
        total++; if (first_rd != sc + 1) begin bad++; $display("FAIL single_first_rd got=%0d want=%0d", first_rd - sc, 1); end
        total++; if (last_rd - first_rd != 15) begin bad++; $display("FAIL single_rd_span got=%0d want=15", last_rd - first_rd); end
    endtask

    task automatic test_ties;
        int lat, sc;
        logic ba;
        fill(20'd3);
        mem[5]  = 20'hFFFFF;
        mem[50] = 20'hFFFFF;
        scan(20'd0, -1, -1, -1, '0, -1, lat, ba, sc);
        total++; if (lat != 19) begin bad++; $display("FAIL tie_x_latency got=%0d want=19", lat); end
        total++; if (peak_idx !== 6'd5) begin bad++; $display("FAIL tie_x_idx got=%0d want=5", peak_idx); end
        total++; if (peak_mag !== 20'hFFFFF) begin bad++; $display("FAIL tie_x_mag got=%0h want=fffff", peak_mag); end
        fill(20'd100);
        mem[8]  = 20'd700;
        mem[9]  = 20'd700;
        mem[10] = 20'd700;
        scan(20'd0, -1, -1, -1, '0, -1, lat, ba, sc);
        total++; if (peak_idx !== 6'd8) begin bad++; $display("FAIL tie_lane_idx got=%0d want=8", peak_idx); end
        total++; if (peak_mag !== 20'd700) begin bad++; $display("FAIL tie_lane_mag got=%0d want=700", peak_mag); end
    endtask

    task automatic test_all_zero;
        int lat, sc;
        logic ba;
        fill(20'd0);
        scan(20'd0, -1, -1, -1, '0, -1, lat, ba, sc);
        total++; if (peak_idx !== 6'd0) begin bad++; $display("FAIL zero_idx got=%0d want=0", peak_idx); end
        total++; if (peak_mag !== 20'd0) begin bad++; $display("FAIL zero_mag got=%0d want=0", peak_mag); end
        total++; if (peak_valid !== 1'b1) begin bad++; $display("FAIL zero_valid_thr0 got=%0b want=1", peak_valid); end
        scan(20'd1, -1, -1, -1, '0, -1, lat, ba, sc);
        total++; if (peak_valid !== 1'b0) begin bad++; $display("FAIL zero_valid_thr1 got=%0b want=0", peak_valid); end
    endtask

    task automatic test_threshold;
        int lat, sc;
        logic ba;
        fill(20'd5);
        mem[63] = 20'd99;
        scan(20'd100, -1, -1, 5, 20'd0, -1, lat, ba, sc);
        total++; if (lat != 19) begin bad++; $display("FAIL thr_latency got=%0d want=19", lat); end
        total++; if (peak_idx !== 6'd63) begin bad++; $display("FAIL thr_idx got=%0d want=63", peak_idx); end
        total++; if (peak_mag !== 20'd99) begin bad++; $display("FAIL thr_mag got=%0d want=99", peak_mag); end
        total++; if (peak_valid !== 1'b0) begin bad++; $display("FAIL thr_valid got=%0b want=0", peak_valid); end
    endtask

    task automatic test_abort_and_restart;
        int lat, sc;
        logic ba;
        fill(20'd1);
        mem[20] = 20'd4000;
        scan(20'd0, 4, 8, -1, '0, -1, lat, ba, sc);
        total++; if (lat != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", lat); end
        total++; if (ba !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", ba); end
        total++; if (peak_idx !== 6'd63) begin bad++; $display("FAIL abort_idx_kept got=%0d want=63", peak_idx); end
        total++; if (peak_mag !== 20'd99) begin bad++; $display("FAIL abort_mag_kept got=%0d want=99", peak_mag); end
        total++; if (peak_valid !== 1'b0) begin bad++; $display("FAIL abort_valid_kept got=%0b want=0", peak_valid); end
        // Second start mid-scan with a raised min_mag must neither restart nor recapture.
        scan(20'd0, 4, -1, 4, 20'hFFFFF, -1, lat, ba, sc);
        total++; if (lat != 19) begin bad++; $display("FAIL restart_latency got=%0d want=19", lat); end
        total++; if (peak_idx !== 6'd20) begin bad++; $display("FAIL restart_idx got=%0d want=20", peak_idx); end
        total++; if (peak_mag !== 20'd4000) begin bad++; $display("FAIL restart_mag got=%0d want=4000", peak_mag); end
        total++; if (peak_valid !== 1'b1) begin bad++; $display("FAIL restart_valid got=%0b want=1", peak_valid); end
    endtask

    task automatic test_reset_mid_scan;
        int lat, sc;
        logic ba;
        fill(20'd2);
        mem[44] = 20'd3000;
        scan(20'd0, -1, -1, -1, '0, 10, lat, ba, sc);
        total++; if (lat != 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", lat); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b want=0", busy); end
        total++; if (peak_idx !== 6'd0) begin bad++; $display("FAIL midrst_idx got=%0d want=0", peak_idx); end
        total++; if (peak_mag !== 20'd0) begin bad++; $display("FAIL midrst_mag got=%0d want=0", peak_mag); end
        total++; if (peak_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b want=0", peak_valid); end
        scan(20'd0, -1, -1, -1, '0, -1, lat, ba, sc);
        total++; if (lat != 19) begin bad++; $display("FAIL postrst_latency got=%0d want=19", lat); end
        total++;
        if (addr_log.size() == 0 || addr_log[0] != 0) begin
            bad++;
            $display("FAIL postrst_first_addr got=%0d want=0",
                     (addr_log.size() == 0) ? -1 : addr_log[0]);
        end
        total++; if (peak_idx !== 6'd44) begin bad++; $display("FAIL postrst_idx got=%0d want=44", peak_idx); end
        total++; if (peak_mag !== 20'd3000) begin bad++; $display("FAIL postrst_mag got=%0d want=3000", peak_mag); end
    endtask

    initial begin
        test_reset();
        test_single_peak();
        test_ties();
        test_all_zero();
        test_threshold();
        test_abort_and_restart();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/peak_bin_scanner.md
Name: peak_bin_scanner

Overview:
- Scans a magnitude memory of NUM_BINS frequency bins and reports the bin with the largest magnitude, its value, and whether that value reaches a programmable threshold.
- The memory is organised as one word of four bins per address.
- Each word goes through a registered four-way max select (ties go to the lowest lane), then into a running-max stage across words.
- Sits between the spectrum/magnitude store and the display/decision logic; it sequences the 4-bin comparison over the whole spectrum.

Parameters:
- NUM_BINS, 64, total bins; must be a multiple of 4 and at least 4.
- MAG_W, 20, magnitude width per bin.
- IDX_W, $clog2(NUM_BINS), bin index width.
- ADDR_W, $clog2(NUM_BINS/4) (minimum 1), memory word address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a scan; accepted only in IDLE.
- abort  in  1  terminates a scan in progress; ignored in IDLE.
- min_mag  in  MAG_W  threshold; captured on the cycle start is accepted.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDR_W  memory word address (group g holds bins 4g..4g+3).
- rd_data  in  4*MAG_W  word returned one cycle after rd_en; lane k (bits [k*MAG_W +: MAG_W]) is bin 4g+k.
- busy  out  1  high from the cycle after start is accepted until done or abort.
- done  out  1  one-cycle pulse when results update.
- peak_idx  out  IDX_W  winning bin index.
- peak_mag  out  MAG_W  winning magnitude.
- peak_valid  out  1  peak_mag >= captured min_mag.

Behaviour:
- Reset (rst_n=0 at an edge): all outputs go to 0, FSM goes to IDLE, pipeline valid bits clear. Reset overrides start and abort. Reset mid-scan drops the scan with no done.
- G = NUM_BINS/4.
- States: IDLE, READ, DRAIN, FINISH.
  - IDLE -> READ when start=1.
  - READ: rd_en=1 and rd_addr=0..G-1 on consecutive cycles; after address G-1 -> DRAIN.
  - DRAIN: waits for the last group to leave the running stage -> FINISH.
  - FINISH: registers outputs, pulses done -> IDLE.
- Stage 1 (group select):
  - Registered on the cycle after rd_data is valid.
  - Selects the lane with the maximum magnitude; equal values resolve to the lowest lane.
  - Registers the lane number (2 bits), the magnitude and a valid bit.
- Stage 2 (running max):
  - The first group of a scan loads unconditionally.
  - Later groups replace the running value only if their magnitude is strictly greater, so cross-group ties keep the earlier bin.
  - Running index = {g, lane}.
- Latency: if start is sampled at edge 0, the first rd_en is in the following cycle. done is high in the cycle following edge G+3, i.e. 19 cycles for NUM_BINS=64. peak_* and peak_valid update at that same edge and hold until the next done or reset.
- busy = (state != IDLE).
- start while busy: ignored; min_mag is not recaptured.
- abort while busy:
  - Next state is IDLE; rd_en drops the next cycle.
  - Pipeline valid bits clear and done does not pulse.
  - peak_* keep their previous results.
- Simultaneous start and abort in IDLE: start wins (abort is ignored in IDLE). Both while busy: abort wins.
- All bins zero: peak_idx=0, peak_mag=0, peak_valid=(min_mag==0).
- Arithmetic: unsigned comparisons only, no width growth.

Decomposition:
- Shared package scan_pkg holds:
  - default MAG_W and NUM_BINS;
  - the state enum (IDLE, READ, DRAIN, FINISH);
  - the lane-select width constant LANE_W=2.
- Sub-module max4_select: four MAG_W inputs with a valid, registered outputs lane/mag/valid, lowest-lane tie rule.
- peak_bin_scanner instantiates max4_select once and contains the FSM, address counter and running-max stage.

Test Plan:
1. Reset check: hold rst_n=0 for 3 cycles with start=1 -> busy=0, done=0, rd_en=0, peak_idx=0, peak_mag=0, peak_valid=0.
2. Single peak, NUM_BINS=64: bin 37=1000, all others=10, min_mag=500 -> done exactly 19 cycles after start; peak_idx=37, peak_mag=1000, peak_valid=1; rd_addr sequence 0..15 with no gaps.
3. Tie handling:
   - bins 5 and 50 both 0xFFFFF -> peak_idx=5.
   - separate scan with bins 8, 9, 10 = 700 as maximum -> peak_idx=8.
4. Threshold: maximum 99 at bin 63, min_mag=100 -> peak_idx=63, peak_mag=99, peak_valid=0. Changing min_mag mid-scan to 0 has no effect.
5. Abort and start-while-busy:
   - start, pulse start again at cycle 4 -> ignored.
   - abort at cycle 8 -> busy=0 next cycle, no done, peak_* unchanged from the prior scan.
   - new start -> full correct result 19 cycles later.
6. Reset mid-scan: rst_n=0 at cycle 10 of a scan -> no done, outputs zeroed. A start after release scans from rd_addr=0 and gives a correct result.
